// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame transmit and receive paths:
// FSM state encoding and serial line levels.
package serial_frame_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } state_e;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   // Even parity: the parity bit makes the total count of ones even.
   function automatic logic even_parity_mismatch(input logic data_xor, input logic par_bit);
      return data_xor ^ par_bit;
   endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in/parallel-out shift register. New bits enter at the MSB, so an
// LSB-first stream lines up with bit 0 after WIDTH shifts.
module sipo_shift_reg #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             shift_en,
   input  logic             si,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (shift_en) begin
         q_d = {si, q_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits LSB first, optional even
// parity, stop bit; the received word is held on a valid/ready output.
module serial_frame_rx
   import serial_frame_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter bit          PARITY_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             si,
   input  logic             bit_en,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             parity_err,
   output logic             frame_err,
   output logic             overrun,
   output logic             busy
);

   localparam int unsigned     CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic               par_bit_q, par_bit_d;
   logic [WIDTH-1:0]   shreg;
   logic               shift_en;
   logic               shreg_clr;

   logic [WIDTH-1:0]   dout_q, dout_d;
   logic               dout_valid_q, dout_valid_d;
   logic               parity_err_q, parity_err_d;
   logic               frame_err_q, frame_err_d;
   logic               overrun_q, overrun_d;
   logic               busy_q, busy_d;

   logic               load_word;
   logic               word_par_err;

   sipo_shift_reg #(
      .WIDTH(WIDTH)
   ) u_shreg (
      .clk      (clk),
      .rst      (rst),
      .clr      (shreg_clr),
      .shift_en (shift_en),
      .si       (si),
      .q        (shreg)
   );

   // Next-state logic; every transition is gated by the bit strobe.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      par_bit_d   = par_bit_q;
      shift_en    = 1'b0;
      shreg_clr   = 1'b0;
      load_word   = 1'b0;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;

      if (bit_en) begin
         case (state_q)
            ST_IDLE: begin
               if (si == START_BIT) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = '0;
                  shreg_clr = 1'b1;
               end
            end
            ST_DATA: begin
               shift_en = 1'b1;
               if (bit_cnt_q == LAST_CNT) begin
                  // Park the counter instead of letting it wrap past WIDTH-1.
                  bit_cnt_d = '0;
                  state_d   = PARITY_EN ? ST_PARITY : ST_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
            ST_PARITY: begin
               par_bit_d = si;
               state_d   = ST_STOP;
            end
            ST_STOP: begin
               state_d = ST_IDLE;
               if (si == STOP_BIT) begin
                  if (!dout_valid_q || dout_ready) begin
                     load_word = 1'b1;
                  end else begin
                     overrun_d = 1'b1;
                  end
               end else begin
                  frame_err_d = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign word_par_err = PARITY_EN & even_parity_mismatch(^shreg, par_bit_q);

   // Output register: a load in the handshake cycle keeps valid high with new data.
   always_comb begin
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      parity_err_d = parity_err_q;
      if (load_word) begin
         dout_d       = shreg;
         dout_valid_d = 1'b1;
         parity_err_d = word_par_err;
      end else if (dout_valid_q && dout_ready) begin
         dout_valid_d = 1'b0;
      end
   end

   assign busy_d = (state_d != ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         bit_cnt_q    <= '0;
         par_bit_q    <= 1'b0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         par_bit_q    <= par_bit_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
         busy_q       <= busy_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: one instance with parity, one without.
module tb_serial_frame_rx;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst, si, si2, bit_en, dout_ready, ready2;
   logic [W-1:0] dout, dout2;
   logic dout_valid, parity_err, frame_err, overrun, busy;
   logic dout_valid2, parity_err2, frame_err2, overrun2, busy2;

   always #5 clk = ~clk;

   serial_frame_rx #(.WIDTH(W), .PARITY_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .si(si), .bit_en(bit_en), .dout(dout), .dout_valid(dout_valid),
      .dout_ready(dout_ready), .parity_err(parity_err), .frame_err(frame_err),
      .overrun(overrun), .busy(busy)
   );

   serial_frame_rx #(.WIDTH(W), .PARITY_EN(1'b0)) dut_np (
      .clk(clk), .rst(rst), .si(si2), .bit_en(bit_en), .dout(dout2), .dout_valid(dout_valid2),
      .dout_ready(ready2), .parity_err(parity_err2), .frame_err(frame_err2),
      .overrun(overrun2), .busy(busy2)
   );

   typedef struct packed {
      logic [W-1:0] data;
      logic         perr;
   } exp_t;

   exp_t         exp_q[$];
   logic [W-1:0] exp2_q[$];
   int checks = 0, errors = 0;
   int fe_seen = 0, ov_seen = 0, fe2_seen = 0, ov2_seen = 0, valid2_cycles = 0;
   int fe_exp = 0, ov_exp = 0;

   int   en_div = 1, en_cnt = 0;
   bit   rnd_ready = 1'b0;
   logic ready_val = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Bit strobe and consumer ready change 2 time units after each rising edge.
   always @(posedge clk) begin
      #2;
      en_cnt     = (en_cnt + 1) % en_div;
      bit_en     = (en_cnt == 0);
      dout_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_val;
   end

   // Monitor: pops the scoreboard on every handshake.
   logic [W-1:0] hold_dout;
   logic         hold_perr;
   logic         hold_pend = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         hold_pend = 1'b0;
      end else begin
         if (frame_err) fe_seen++;
         if (overrun) ov_seen++;
         if (frame_err2) fe2_seen++;
         if (overrun2) ov2_seen++;
         if (hold_pend) begin
            check("hold_valid", dout_valid, 1);
            check("hold_dout", dout, hold_dout);
            check("hold_parity_err", parity_err, hold_perr);
         end
         hold_pend = dout_valid && !dout_ready;
         hold_dout = dout;
         hold_perr = parity_err;
         if (dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_word: got 0x%0h, expected no word", dout);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("dout", dout, e.data);
               check("parity_err", parity_err, e.perr);
            end
         end
         if (dout_valid2) begin
            valid2_cycles++;
            if (exp2_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_word2: got 0x%0h, expected no word", dout2);
            end else begin
               check("dout2", dout2, exp2_q.pop_front());
               check("parity_err2", parity_err2, 0);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input logic b2);
      si  = b;
      si2 = b2;
      do @(posedge clk); while (!bit_en);
      #1;
   endtask

   // Frame on the line, LSB first: start, data, optional parity, stop.
   task automatic build(input logic [W-1:0] d, input logic pen, input logic pflip,
                        input logic stop, output logic [W+2:0] f, output int n);
      f    = '1;
      f[0] = 1'b0;
      for (int i = 0; i < W; i++) f[i+1] = d[i];
      n = W + 1;
      if (pen) begin
         f[n] = (^d) ^ pflip;
         n++;
      end
      f[n] = stop;
      n++;
   endtask

   task automatic send_frame(input logic [W-1:0] d, input logic pflip, input logic stop);
      logic [W+2:0] f;
      int n;
      build(d, 1'b1, pflip, stop, f, n);
      for (int i = 0; i < n; i++) send_bit(f[i], 1'b1);
      si = 1'b1;
   endtask

   task automatic wait_drain(input int budget);
      int k = 0;
      while ((exp_q.size() != 0 || exp2_q.size() != 0) && k < budget) begin
         tick();
         k++;
      end
      if (exp_q.size() != 0 || exp2_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d words pending, expected 0",
                  exp_q.size() + exp2_q.size());
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [W+2:0] f, g;
      int n, m, fe0, ov0, v0;
      logic [W-1:0] d;
      logic pflip, stop;

      si = 1'b1; si2 = 1'b1; rst = 1'b1; bit_en = 1'b0; dout_ready = 1'b0; ready2 = 1'b1;
      repeat (3) tick();
      check("rst_dout", dout, 0);
      check("rst_valid", dout_valid, 0);
      check("rst_parity_err", parity_err, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_overrun", overrun, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      tick();

      // 0xA5 with good parity, explicit latency check.
      ready_val = 1'b0;
      build(8'hA5, 1'b1, 1'b0, 1'b1, f, n);
      send_bit(f[0], 1'b1);
      check("busy_after_start", busy, 1);
      for (int i = 1; i < n - 1; i++) send_bit(f[i], 1'b1);
      check("valid_before_stop", dout_valid, 0);
      send_bit(f[n-1], 1'b1);
      si = 1'b1;
      check("a5_valid", dout_valid, 1);
      check("a5_dout", dout, 8'hA5);
      check("a5_parity_err", parity_err, 0);
      exp_q.push_back('{8'hA5, 1'b0});
      ready_val = 1'b1;
      wait_drain(50);

      // Parity bit flipped.
      exp_q.push_back('{8'hA5, 1'b1});
      send_frame(8'hA5, 1'b1, 1'b1);
      wait_drain(50);

      // Bad stop bit.
      fe0 = fe_seen;
      send_frame(8'h3C, 1'b0, 1'b0);
      fe_exp++;
      tick(); tick();
      check("frame_err_pulses", fe_seen - fe0, 1);
      check("frame_err_valid", dout_valid, 0);
      check("frame_err_idle", busy, 0);

      // Overrun: second frame arrives while the first is still pending.
      ready_val = 1'b0;
      ov0 = ov_seen;
      exp_q.push_back('{8'h11, 1'b0});
      send_frame(8'h11, 1'b0, 1'b1);
      send_frame(8'h22, 1'b0, 1'b1);
      ov_exp++;
      tick(); tick();
      check("overrun_pulses", ov_seen - ov0, 1);
      check("overrun_dout", dout, 8'h11);
      check("overrun_valid", dout_valid, 1);
      ready_val = 1'b1;
      tick();
      ready_val = 1'b0;
      exp_q.push_back('{8'h33, 1'b0});
      send_frame(8'h33, 1'b0, 1'b1);
      check("after_overrun_dout", dout, 8'h33);
      ready_val = 1'b1;
      wait_drain(50);

      // Slow strobe, pending word, reset mid-frame, then resend.
      en_div = 4;
      ready_val = 1'b0;
      send_frame(8'h77, 1'b0, 1'b1);
      build(8'h5A, 1'b1, 1'b0, 1'b1, f, n);
      for (int i = 0; i < 5; i++) send_bit(f[i], 1'b1);
      si = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_dout", dout, 0);
      check("midrst_valid", dout_valid, 0);
      check("midrst_parity_err", parity_err, 0);
      check("midrst_busy", busy, 0);
      ready_val = 1'b1;
      exp_q.push_back('{8'h5A, 1'b0});
      send_frame(8'h5A, 1'b0, 1'b1);
      wait_drain(100);

      // No-parity instance: back-to-back 0x00 and 0xFF.
      en_div = 1;
      v0 = valid2_cycles;
      build(8'h00, 1'b0, 1'b0, 1'b1, f, n);
      build(8'hFF, 1'b0, 1'b0, 1'b1, g, m);
      exp2_q.push_back(8'h00);
      exp2_q.push_back(8'hFF);
      for (int i = 0; i < n; i++) send_bit(1'b1, f[i]);
      for (int i = 0; i < m; i++) send_bit(1'b1, g[i]);
      si2 = 1'b1;
      repeat (3) tick();
      check("np_valid_cycles", valid2_cycles - v0, 2);
      wait_drain(20);

      // Randomized frames against the scoreboard.
      rnd_ready = 1'b1;
      for (int k = 0; k < 25; k++) begin
         en_div = $urandom_range(1, 3);
         d      = W'($urandom);
         pflip  = ($urandom_range(0, 3) == 0);
         stop   = ($urandom_range(0, 5) != 0);
         if (stop) exp_q.push_back('{d, pflip});
         else fe_exp++;
         send_frame(d, pflip, stop);
         repeat ($urandom_range(0, 3)) tick();
         wait_drain(200);
      end
      rnd_ready = 1'b0;
      repeat (4) tick();

      check("total_frame_err", fe_seen, fe_exp);
      check("total_overrun", ov_seen, ov_exp);
      check("np_frame_err", fe2_seen, 0);
      check("np_overrun", ov2_seen, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Serial frame receiver: the receive-side counterpart of the team's serial shift-register transmit path. It watches a one-bit serial line, detects a start bit, and shifts in WIDTH data bits LSB-first. It checks optional even parity and the stop bit, then presents the word on a parallel valid/ready output. It sits between the serial pin/link and any parallel consumer (FIFO, register file).

## Interface
- WIDTH, 8: data bits per frame, 2..32.
- PARITY_EN, 1: 1 = one even-parity bit follows the data; 0 = no parity bit.

- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- si  input  1  serial line; idle level 1.
- bit_en  input  1  bit strobe; si is sampled only on cycles with bit_en=1.
- dout  output  WIDTH  received word; valid while dout_valid=1.
- dout_valid  output  1  word available; held until accepted.
- dout_ready  input  1  consumer accepts; handshake = dout_valid & dout_ready.
- parity_err  output  1  parity mismatch for the word on dout; qualified by dout_valid.
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0; frame dropped.
- overrun  output  1  one-cycle pulse: good frame completed while output was still occupied; new frame dropped.
- busy  output  1  1 in any state other than IDLE.

## Operation
- Frame on the line: start (0), WIDTH data bits LSB first, parity bit if PARITY_EN, stop (1). That is WIDTH+2+PARITY_EN bits in total.
- The state machine has four states: IDLE, DATA, PARITY, STOP. It advances only on bit_en=1 cycles and holds otherwise.
- IDLE: si=0 sampled → DATA, bit_cnt←0. si=1 → stay in IDLE.
- DATA: shreg←{si, shreg[WIDTH-1:1]} and bit_cnt←bit_cnt+1. When bit_cnt=WIDTH-1 → PARITY if PARITY_EN, else STOP.
- PARITY: par_bit←si → STOP.
- STOP, with si=1 (good frame):
  - Output register free (dout_valid=0), or freed this cycle (dout_valid & dout_ready):
    - dout←shreg, dout_valid←1.
    - parity_err←PARITY_EN & (^shreg ^ par_bit).
  - Otherwise: overrun pulses for one cycle; dout and parity_err are unchanged.
  - Next state is IDLE.
- STOP, with si=0: frame_err pulses for one cycle, nothing is loaded, next state is IDLE. A 0 here is never treated as a new start bit.
- Output side: dout_valid clears on a handshake unless a new word is loaded in the same cycle, in which case it stays 1 with the new data.
- bit_cnt is $clog2(WIDTH) bits wide and never wraps inside a frame.

## Timing
- Reset values:
  - State IDLE; bit_cnt, shreg and par_bit 0.
  - dout=0, dout_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
- rst=1 during a frame aborts it immediately. A word already pending on dout is also cleared.
- Latency with bit_en held at 1: start bit sampled at edge 0, stop bit at edge WIDTH+1+PARITY_EN. dout_valid, frame_err and overrun are registered at that edge and visible in the following cycle.
- The earliest next start bit is sampled one bit_en cycle after the stop bit, giving back-to-back frames with no idle gap.
- dout and parity_err are stable while dout_valid=1 and no handshake has occurred.
- busy is registered and goes to 1 in the cycle after the start bit is sampled.
- bit_en=0 in mid-frame freezes state, bit_cnt and shreg indefinitely.

## Structure
- Shared package serial_frame_pkg holds:
  - state encoding constants ST_IDLE, ST_DATA, ST_PARITY, ST_STOP (2 bits);
  - LINE_IDLE=1, START_BIT=0, STOP_BIT=1.
  - The transmit side uses the same package.
- One sub-module, sipo_shift_reg: WIDTH-bit serial-in/parallel-out register with shift enable and synchronous clear. The top level holds the FSM, bit counter, parity check and output register.

## Test plan
- WIDTH=8, PARITY_EN=1, bit_en=1: send 0xA5 (bits 1,0,1,0,0,1,0,1, parity 0, stop 1) → dout=0xA5, dout_valid=1, parity_err=0, 11 cycles after the start edge.
- Same frame with the parity bit flipped to 1 → dout=0xA5, dout_valid=1, parity_err=1.
- Send 0x3C with stop bit 0 → frame_err pulses for exactly one cycle, dout_valid stays 0, state returns to IDLE.
- dout_ready=0: send 0x11 then 0x22 back-to-back → dout stays 0x11, overrun pulses once. Then dout_ready=1 for one cycle and send 0x33 → dout=0x33.
- bit_en=1 every 4th cycle, send 0x5A, and assert rst for one cycle in mid-frame before resending 0x5A → first frame discarded with all outputs at reset values, second frame yields dout=0x5A.
- PARITY_EN=0: continuous frames 0x00 and 0xFF with no idle gap, dout_ready=1 → two words, each valid for one cycle, no error flags.
